// File: rtl/read_buf_pkg.sv
// Shared types and width helpers for the read buffer controller.
package read_buf_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      FILL  = 2'd2
   } rbuf_state_e;

   localparam int RBUF_DATA_WIDTH  = 512;
   localparam int RBUF_ADDR_WIDTH  = 32;
   localparam int RBUF_BUFFER_SIZE = 128;
   localparam int RBUF_MAX_BURST   = 16;

   localparam int RBUF_PTR_W = $clog2(RBUF_BUFFER_SIZE);
   localparam int RBUF_CNT_W = RBUF_PTR_W + 1;
   localparam int RBUF_LEN_W = $clog2(RBUF_MAX_BURST) + 1;

   // count must reach BUFFER_SIZE itself, hence one bit more than the pointers
   function automatic int rbuf_cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic int rbuf_len_w(input int max_burst);
      return $clog2(max_burst) + 1;
   endfunction

endpackage

// File: rtl/read_buf_ctrl_if.sv
// Client request, DRAM command/response and consumer drain handshakes of read_buf_ctrl.
interface read_buf_ctrl_if #(
   parameter int DATA_WIDTH = 512,
   parameter int ADDR_WIDTH = 32,
   parameter int LEN_W      = 5
);
   logic                  req_valid;
   logic                  req_ready;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [LEN_W-1:0]      req_len;
   logic                  mem_req_valid;
   logic                  mem_req_ready;
   logic [ADDR_WIDTH-1:0] mem_req_addr;
   logic [LEN_W-1:0]      mem_req_len;
   logic                  mem_rsp_valid;
   logic                  mem_rsp_ready;
   logic [DATA_WIDTH-1:0] mem_rsp_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;

   // slave: the buffer controller; master: the surrounding client, DRAM and consumer
   modport slave (
      input  req_valid, req_addr, req_len, mem_req_ready, mem_rsp_valid, mem_rsp_data, out_ready,
      output req_ready, mem_req_valid, mem_req_addr, mem_req_len, mem_rsp_ready, out_valid, out_data
   );

   modport master (
      output req_valid, req_addr, req_len, mem_req_ready, mem_rsp_valid, mem_rsp_data, out_ready,
      input  req_ready, mem_req_valid, mem_req_addr, mem_req_len, mem_rsp_ready, out_valid, out_data
   );
endinterface

// File: rtl/rbuf_mem.sv
// Line buffer storage: registered write port, combinational read port.
module rbuf_mem #(
   parameter int DATA_WIDTH = 512,
   parameter int DEPTH      = 128,
   parameter int AW         = $clog2(DEPTH)
)(
   input  logic                  clk,
   input  logic                  we,
   input  logic [AW-1:0]         waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [AW-1:0]         raddr,
   output logic [DATA_WIDTH-1:0] rdata
);
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // contents are intentionally not reset; validity is tracked by the controller
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/read_buf_ctrl_chk.sv
// Protocol checks for read_buf_ctrl: a beat must never be written into a full buffer.
module read_buf_ctrl_chk (
   input logic clk,
   input logic reset,
   input logic wr_en,
   input logic full
);
   a_no_write_when_full: assert property (@(posedge clk) disable iff (reset) !(wr_en && full));
endmodule

// File: rtl/read_buf_ctrl.sv
// Reserves line-buffer space, issues one DRAM read burst at a time and drains beats in FIFO order.
// Optional statistics counters are built when READ_BUF_STATS_EN is defined.
module read_buf_ctrl
   import read_buf_pkg::*;
#(
   parameter int DATA_WIDTH  = RBUF_DATA_WIDTH,
   parameter int BUFFER_SIZE = RBUF_BUFFER_SIZE,
   parameter int ADDR_WIDTH  = RBUF_ADDR_WIDTH,
   parameter int MAX_BURST   = RBUF_MAX_BURST
)(
   input  logic                         clk,
   input  logic                         reset,
   read_buf_ctrl_if.slave               bus,
   output logic [$clog2(BUFFER_SIZE):0] occupancy,
   output logic                         busy,
   output logic [$clog2(BUFFER_SIZE):0] stat_hwm,
   output logic [31:0]                  stat_stall_cyc
);
   localparam int PTR_W = $clog2(BUFFER_SIZE);
   localparam int CNT_W = rbuf_cnt_w(BUFFER_SIZE);
   localparam int LEN_W = rbuf_len_w(MAX_BURST);

   rbuf_state_e           state, state_next;
   logic [PTR_W-1:0]      wr_ptr, rd_ptr;
   logic [CNT_W-1:0]      count, count_next;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [LEN_W-1:0]      len_q, beat_cnt;
   logic [DATA_WIDTH-1:0] rdata;
   logic req_ready, mem_req_valid, mem_rsp_ready;
   logic space_ok, wr_en, pop, out_valid, accept, cmd_fire;

   assign space_ok  = (CNT_W'(BUFFER_SIZE) - count) >= CNT_W'(len_q);
   assign out_valid = (count != {CNT_W{1'b0}});
   assign wr_en     = mem_rsp_ready && bus.mem_rsp_valid;
   assign pop       = out_valid && bus.out_ready;
   assign accept    = req_ready && bus.req_valid && (bus.req_len != {LEN_W{1'b0}});
   assign cmd_fire  = mem_req_valid && bus.mem_req_ready;

   // next-state and handshake outputs
   always_comb begin
      state_next    = state;
      req_ready     = 1'b0;
      mem_req_valid = 1'b0;
      mem_rsp_ready = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (accept) state_next = ISSUE;
            else        state_next = IDLE;
         end
         ISSUE: begin
            mem_req_valid = space_ok;
            if (space_ok && bus.mem_req_ready) state_next = FILL;
            else                               state_next = ISSUE;
         end
         FILL: begin
            mem_rsp_ready = 1'b1;
            if (bus.mem_rsp_valid && (beat_cnt == len_q - LEN_W'(1))) state_next = IDLE;
            else                                                      state_next = FILL;
         end
         default: state_next = IDLE;
      endcase
   end

   // occupancy update; a simultaneous write and pop cancel out
   always_comb begin
      count_next = count;
      case ({wr_en, pop})
         2'b10:   count_next = count + CNT_W'(1);
         2'b01:   count_next = count - CNT_W'(1);
         default: count_next = count;
      endcase
   end

   // state register, pointers and latched request
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         wr_ptr   <= {PTR_W{1'b0}};
         rd_ptr   <= {PTR_W{1'b0}};
         count    <= {CNT_W{1'b0}};
         addr_q   <= {ADDR_WIDTH{1'b0}};
         len_q    <= {LEN_W{1'b0}};
         beat_cnt <= {LEN_W{1'b0}};
      end else begin
         state <= state_next;
         count <= count_next;
         if (accept) begin
            addr_q <= bus.req_addr;
            len_q  <= bus.req_len;
         end
         if (cmd_fire)   beat_cnt <= {LEN_W{1'b0}};
         else if (wr_en) beat_cnt <= beat_cnt + LEN_W'(1);
         if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      end
   end

   rbuf_mem #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(BUFFER_SIZE), .AW(PTR_W)) u_mem (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wr_ptr),
      .wdata (bus.mem_rsp_data),
      .raddr (rd_ptr),
      .rdata (rdata)
   );

   read_buf_ctrl_chk u_chk (
      .clk   (clk),
      .reset (reset),
      .wr_en (wr_en),
      .full  (count == CNT_W'(BUFFER_SIZE))
   );

   assign bus.req_ready     = req_ready;
   assign bus.mem_req_valid = mem_req_valid;
   assign bus.mem_req_addr  = addr_q;
   assign bus.mem_req_len   = len_q;
   assign bus.mem_rsp_ready = mem_rsp_ready;
   assign bus.out_valid     = out_valid;
   // zero when empty so a freshly reset block presents all-zero outputs
   assign bus.out_data      = out_valid ? rdata : {DATA_WIDTH{1'b0}};
   assign occupancy         = count;
   assign busy              = (state != IDLE);

`ifdef READ_BUF_STATS_EN
   logic [CNT_W-1:0] hwm;
   logic [31:0]      stall_cyc;

   // peak occupancy and saturating space-wait cycle counter
   always_ff @(posedge clk) begin
      if (reset) begin
         hwm       <= {CNT_W{1'b0}};
         stall_cyc <= 32'd0;
      end else begin
         if (count_next > hwm) hwm <= count_next;
         if ((state == ISSUE) && !space_ok && (stall_cyc != 32'hFFFF_FFFF)) begin
            stall_cyc <= stall_cyc + 32'd1;
         end
      end
   end

   assign stat_hwm       = hwm;
   assign stat_stall_cyc = stall_cyc;
`else
   assign stat_hwm       = {CNT_W{1'b0}};
   assign stat_stall_cyc = 32'd0;
`endif
endmodule

// File: tb/tb_read_buf_ctrl.sv
// Randomized bench for read_buf_ctrl against a queue-based reference model.
module tb_read_buf_ctrl;
   localparam int DW = 512;
   localparam int BS = 128;
   localparam int AW = 32;
   localparam int MB = 16;
   localparam int CW = $clog2(BS) + 1;
   localparam int LW = $clog2(MB) + 1;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [CW-1:0] occupancy, stat_hwm;
   logic          busy;
   logic [31:0]   stat_stall_cyc;

   read_buf_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_W(LW)) bus ();

   read_buf_ctrl #(.DATA_WIDTH(DW), .BUFFER_SIZE(BS), .ADDR_WIDTH(AW), .MAX_BURST(MB)) dut (
      .clk            (clk),
      .reset          (reset),
      .bus            (bus),
      .occupancy      (occupancy),
      .busy           (busy),
      .stat_hwm       (stat_hwm),
      .stat_stall_cyc (stat_stall_cyc)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // reference model: buffered beats plus the one outstanding request
   logic [DW-1:0] q[$];
   bit            m_busy, m_issued;
   logic [AW-1:0] m_addr;
   int            m_len, m_left, m_hwm, rsp_pending, dut_cmds;
   longint        m_stall;
   int            rsp_pct = 100;
   int            or_mode = 0;   // 0 hold, 1 toggle, 2 random
   bit            mrr_rand = 1'b0;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] rand_beat();
      logic [DW-1:0] b;
      for (int i = 0; i < DW / 32; i++) b[i*32 +: 32] = $urandom;
      return b;
   endfunction

   task automatic model_clear();
      q.delete();
      m_busy = 1'b0; m_issued = 1'b0; m_addr = '0; m_len = 0; m_left = 0;
      m_hwm = 0; m_stall = 0; rsp_pending = 0;
   endtask

   // one clock: compare at negedge, advance the model, drive next inputs after posedge
   task automatic cycle();
      bit e_space, e_mrv, pop, push, cmd, acc;
      @(negedge clk);
      e_space = (BS - q.size()) >= m_len;
      e_mrv   = m_busy && !m_issued && e_space;
      if (!reset) begin
         check("req_ready", bus.req_ready, !m_busy);
         check("mem_req_valid", bus.mem_req_valid, e_mrv);
         if (e_mrv) begin
            check("mem_req_addr", bus.mem_req_addr, m_addr);
            check("mem_req_len", bus.mem_req_len, m_len);
         end
         check("mem_rsp_ready", bus.mem_rsp_ready, m_busy && m_issued);
         check("out_valid", bus.out_valid, q.size() != 0);
         if (q.size() != 0) check("out_data", bus.out_data, q[0]);
         check("occupancy", occupancy, q.size());
         check("busy", busy, m_busy);
`ifdef READ_BUF_STATS_EN
         check("stat_hwm", stat_hwm, m_hwm);
         check("stat_stall_cyc", stat_stall_cyc, m_stall);
`else
         check("stat_hwm", stat_hwm, 0);
         check("stat_stall_cyc", stat_stall_cyc, 0);
`endif
         if (bus.mem_req_valid && bus.mem_req_ready) dut_cmds++;
      end
      pop  = (q.size() != 0) && bus.out_ready;
      push = m_busy && m_issued && bus.mem_rsp_valid;
      cmd  = e_mrv && bus.mem_req_ready;
      acc  = !m_busy && bus.req_valid;
      if (m_busy && !m_issued && !e_space) m_stall++;
      if (pop) void'(q.pop_front());
      if (push) begin
         q.push_back(bus.mem_rsp_data);
         m_left--; rsp_pending--;
         if (m_left == 0) begin m_busy = 1'b0; m_issued = 1'b0; end
      end
      if (cmd) begin m_issued = 1'b1; m_left = m_len; rsp_pending = m_len; end
      if (acc && bus.req_len != 0) begin
         m_busy = 1'b1; m_issued = 1'b0; m_addr = bus.req_addr; m_len = int'(bus.req_len);
      end
      if (q.size() > m_hwm) m_hwm = q.size();
      if (reset) model_clear();
      @(posedge clk);
      #1;
      if (acc) bus.req_valid = 1'b0;
      bus.mem_rsp_valid = (rsp_pending > 0) && ($urandom_range(99) < rsp_pct);
      bus.mem_rsp_data  = rand_beat();
      case (or_mode)
         1:       bus.out_ready = ~bus.out_ready;
         2:       bus.out_ready = 1'($urandom_range(1));
         default: ;
      endcase
      if (mrr_rand) bus.mem_req_ready = 1'($urandom_range(1));
   endtask

   task automatic issue_req(input logic [AW-1:0] a, input int len);
      int n = 0;
      bus.req_valid = 1'b1; bus.req_addr = a; bus.req_len = LW'(len);
      while (bus.req_valid && n < 3000) begin cycle(); n++; end
      check("req_accept_bound", n < 3000, 1'b1);
      bus.req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (m_busy && n < 3000) begin cycle(); n++; end
      check("idle_bound", n < 3000, 1'b1);
   endtask

   task automatic drain();
      int n = 0;
      or_mode = 0; bus.out_ready = 1'b1;
      while (q.size() != 0 && n < 500) begin cycle(); n++; end
      check("drain_bound", n < 500, 1'b1);
   endtask

   initial begin
      bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_len = '0;
      bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rsp_data = '0;
      bus.out_ready = 1'b0;
      model_clear(); dut_cmds = 0;
      repeat (2) cycle();
      reset = 1'b0;
      repeat (2) cycle();

      // basic burst
      bus.mem_req_ready = 1'b1; bus.out_ready = 1'b1; dut_cmds = 0;
      issue_req(32'h0000_1000, 4);
      wait_idle();
      repeat (4) cycle();
      check("basic_cmd_count", dut_cmds, 1);
      check("basic_occ_end", occupancy, 0);

      // zero-length request is dropped
      dut_cmds = 0;
      issue_req(32'h0000_2000, 0);
      repeat (3) cycle();
      check("len0_no_cmd", dut_cmds, 0);
      check("len0_busy", busy, 1'b0);

      // space wait: preload 120 beats, then a 16-beat request must wait
      bus.out_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         issue_req(32'h0001_0000 + 32'(i * 1024), (i < 7) ? 16 : 8);
         wait_idle();
      end
      repeat (2) cycle();
      check("preload_occ", occupancy, 120);
      bus.mem_req_ready = 1'b0;
      issue_req(32'h0002_0000, 16);
      repeat (6) cycle();
      check("space_wait_valid", bus.mem_req_valid, 1'b0);
`ifdef READ_BUF_STATS_EN
      check("space_wait_hwm", stat_hwm, 120);
`endif
      bus.out_ready = 1'b1;
      repeat (8) cycle();
      bus.out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cycle();
         check("held_valid", bus.mem_req_valid, 1'b1);
      end
      bus.mem_req_ready = 1'b1;
      wait_idle();
      drain();

      // wrap and concurrency: 9 x 16 beats with out_ready toggling
      or_mode = 1; rsp_pct = 60;
      for (int i = 0; i < 9; i++) issue_req($urandom, 16);
      wait_idle();
      drain();

      // random traffic
      or_mode = 2; mrr_rand = 1'b1; rsp_pct = 70;
      for (int i = 0; i < 1500; i++) begin
         if (!bus.req_valid && $urandom_range(3) == 0) begin
            bus.req_valid = 1'b1; bus.req_addr = $urandom; bus.req_len = LW'($urandom_range(MB));
         end
         cycle();
      end
      bus.req_valid = 1'b0; mrr_rand = 1'b0; bus.mem_req_ready = 1'b1;
      wait_idle();
      drain();

      // reset in FILL after 2 of 8 beats
      rsp_pct = 100; bus.out_ready = 1'b0;
      issue_req(32'h0003_0000, 8);
      for (int n = 0; n < 50 && !(m_issued && m_left == 6); n++) cycle();
      check("fill_progress", m_left, 6);
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      check("rst_occupancy", occupancy, 0);
      check("rst_busy", busy, 1'b0);
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_out_data", bus.out_data, 0);
      check("rst_req_ready", bus.req_ready, 1'b1);
      check("rst_mem_req_valid", bus.mem_req_valid, 1'b0);
      check("rst_mem_req_addr", bus.mem_req_addr, 0);
      check("rst_mem_rsp_ready", bus.mem_rsp_ready, 1'b0);
      repeat (3) cycle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
